// File: rtl/bcd_updown_counter_if.sv
// Bundle of the counter's control, load and status signals.
// The master side drives enable, direction and load; the slave (the counter)
// returns the count, terminal count and the two one-cycle status pulses.
interface bcd_updown_counter_if #(
  parameter int DIGITS = 2
);
  localparam int W = 4 * DIGITS;

  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  modport master (
    output en, up, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, tc, wrap, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit synchronous BCD up/down counter with parallel load.
// All digits update on the same clock edge; the carry/borrow chain is
// purely combinational. tc is combinational so instances cascade through
// tc -> en with no added latency.
// Optional build macro: BCD_CNT_SATURATE_EN -- when defined the count
// saturates at all-9s / all-0s instead of wrapping, and wrap flags every
// attempted step past the limit.
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter int W      = 4 * DIGITS  // derived; leave at default
) (
  input logic                    clk,
  input logic                    rst,   // synchronous, active-low
  bcd_updown_counter_if.slave    bus
);

  logic [W-1:0]      r_q;
  logic              r_wrap;
  logic              r_load_err;

  logic [DIGITS-1:0] w_lim;      // digit sits at the limit for the current direction
  logic [DIGITS-1:0] w_chain;    // carry/borrow arriving at each digit
  logic [DIGITS-1:0] w_bad;      // load digit out of BCD range
  logic [W-1:0]      w_count_q;  // value after one count step
  logic [W-1:0]      w_load_q;   // sanitised load value
  logic              w_term;     // every digit at its limit: next step wraps

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_step;
      logic [3:0] w_ld;

      assign w_d       = r_q[4*gi +: 4];
      assign w_lim[gi] = bus.up ? (w_d == 4'd9) : (w_d == 4'd0);

      // Digit 0 always receives the step; higher digits only when every
      // lower digit is at its limit. Built from w_lim so no bit of w_chain
      // depends on another bit of itself.
      if (gi == 0) begin : g_first
        assign w_chain[gi] = 1'b1;
      end else begin : g_rest
        assign w_chain[gi] = &w_lim[gi-1:0];
      end

      assign w_step = !w_chain[gi] ? w_d :
                      bus.up       ? ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1) :
                                     ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
      assign w_count_q[4*gi +: 4] = w_step;

      // Non-BCD load digits are forced to zero so q is always valid BCD.
      assign w_ld                = bus.load_val[4*gi +: 4];
      assign w_bad[gi]           = (w_ld > 4'd9);
      assign w_load_q[4*gi +: 4] = w_bad[gi] ? 4'd0 : w_ld;
    end
  endgenerate

  assign w_term = &w_lim;

  // Count state and status pulses: reset > load > count > hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q        <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (bus.load) begin
      r_q        <= w_load_q;
      r_wrap     <= 1'b0;
      r_load_err <= |w_bad;
    end else if (bus.en) begin
`ifdef BCD_CNT_SATURATE_EN
      if (!w_term) begin
        r_q <= w_count_q;
      end
`else
      r_q <= w_count_q;
`endif
      r_wrap     <= w_term;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign bus.q        = r_q;
  assign bus.tc       = bus.en & w_term;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter with DIGITS=2.
// A vector table covers reset, load validation, direction/hold, wrap and
// limit behaviour; a loop then counts through the full 0..99 range.
module tb_bcd_updown_counter;

`ifdef BCD_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  bcd_updown_counter_if #(.DIGITS(2)) bus ();

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] lv;
    logic [7:0] q;
    logic       wrap;
    logic       lerr;
    logic       tc;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                              input logic [7:0] lv, input logic [7:0] q,
                              input logic w, input logic le, input logic tc);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
    v.q = q; v.wrap = w; v.lerr = le; v.tc = tc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [7:0] lv);
    rst = r; bus.en = e; bus.up = u; bus.load = l; bus.load_val = lv;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, o;
    t = 4'(n / 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  initial begin
    //            rst en up ld  lv     q      wrap lerr tc
    vecs[0]  = mk(0, 1, 1, 1, 8'h57, 8'h00, 0, 0, 0);
    vecs[1]  = mk(0, 1, 1, 1, 8'h57, 8'h00, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1, 1, 8'h3C, 8'h30, 0, 1, 0);
    vecs[3]  = mk(1, 0, 1, 1, 8'hF9, 8'h09, 0, 1, 0);
    vecs[4]  = mk(1, 0, 1, 1, 8'h42, 8'h42, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 8'h50, 8'h50, 0, 0, 0);
    vecs[6]  = mk(1, 1, 1, 0, 8'h00, 8'h51, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 8'h00, 8'h50, 0, 0, 0);
    vecs[8]  = mk(1, 1, 1, 0, 8'h00, 8'h51, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 8'h00, 8'h51, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 8'h00, 8'h51, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 1, 8'h10, 8'h10, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 8'h00, 8'h09, 0, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 8'h00, 8'h08, 0, 0, 0);
    vecs[14] = mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
    vecs[16] = mk(1, 1, 0, 0, 8'h00, SAT ? 8'h00 : 8'h99, 1, 0, SAT);
    vecs[17] = mk(1, 1, 1, 0, 8'h00, SAT ? 8'h01 : 8'h00, SAT ? 1'b0 : 1'b1, 0, 0);
    vecs[18] = mk(1, 1, 1, 1, 8'h98, 8'h98, 0, 0, 0);
    vecs[19] = mk(1, 1, 1, 0, 8'h00, 8'h99, 0, 0, 1);
    vecs[20] = mk(1, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h00, 1, 0, SAT);
    vecs[21] = mk(1, 1, 1, 0, 8'h00, SAT ? 8'h99 : 8'h01, SAT, 0, SAT);
    vecs[22] = mk(1, 0, 1, 1, 8'h01, 8'h01, 0, 0, 0);
    vecs[23] = mk(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    vecs[24] = mk(1, 1, 0, 0, 8'h00, SAT ? 8'h00 : 8'h99, 1, 0, SAT);
    vecs[25] = mk(1, 1, 0, 0, 8'h00, SAT ? 8'h00 : 8'h98, SAT, 0, SAT);
    vecs[26] = mk(0, 1, 0, 1, 8'h77, 8'h00, 0, 0, 1);
    vecs[27] = mk(1, 0, 0, 1, 8'hAA, 8'h00, 0, 1, 0);
    vecs[28] = mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    drive(0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
      @(posedge clk); #1;
      $display("vec %0d: rst=%0b en=%0b up=%0b load=%0b lv=%02h -> q=%02h wrap=%0b lerr=%0b tc=%0b",
               i, rst, bus.en, bus.up, bus.load, bus.load_val,
               bus.q, bus.wrap, bus.load_err, bus.tc);
      check($sformatf("vec%0d_q", i),    32'(bus.q),        32'(vecs[i].q));
      check($sformatf("vec%0d_wrap", i), 32'(bus.wrap),     32'(vecs[i].wrap));
      check($sformatf("vec%0d_lerr", i), 32'(bus.load_err), 32'(vecs[i].lerr));
      check($sformatf("vec%0d_tc", i),   32'(bus.tc),       32'(vecs[i].tc));
    end

    // Full-range up count from reset: 00,01..99 then 00 (or held at 99).
    drive(0, 0, 1, 0, 8'h00);
    @(posedge clk); #1;
    check("count_reset_q", 32'(bus.q), 32'h00);
    begin
      int cnt;
      int nxt;
      logic exp_wrap;
      cnt = 0;
      drive(1, 1, 1, 0, 8'h00);
      for (int k = 0; k < 101; k++) begin
        exp_wrap = (cnt == 99);
        nxt = (cnt == 99) ? (SAT ? 99 : 0) : cnt + 1;
        @(posedge clk); #1;
        $display("count edge %0d: q=%02h wrap=%0b tc=%0b", k, bus.q, bus.wrap, bus.tc);
        check($sformatf("count%0d_q", k),    32'(bus.q),    32'(to_bcd(nxt)));
        check($sformatf("count%0d_wrap", k), 32'(bus.wrap), 32'(exp_wrap));
        check($sformatf("count%0d_tc", k),   32'(bus.tc),   32'(nxt == 99));
        cnt = nxt;
      end
    end

    // en low after counting: value holds and tc stays low.
    drive(1, 0, 1, 0, 8'h00);
    @(posedge clk); #1;
    $display("hold: q=%02h wrap=%0b tc=%0b", bus.q, bus.wrap, bus.tc);
    check("hold_q",    32'(bus.q),    32'(to_bcd(SAT ? 99 : 1)));
    check("hold_wrap", 32'(bus.wrap), 32'h0);
    check("hold_tc",   32'(bus.tc),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
